// File: rtl/ldtu_pkg.sv
// Shared definitions for the LiTe-DTU gain-selection control path:
// mode encodings, controller FSM states and FIFO geometry constants.
package ldtu_pkg;

    localparam logic [1:0] MODE_WIN8  = 2'b00;
    localparam logic [1:0] MODE_WIN16 = 2'b01;
    localparam logic [1:0] MODE_G10   = 2'b10;
    localparam logic [1:0] MODE_G1    = 2'b11;

    // Read/write pointer distance of the iFIFO; added to every window flush.
    localparam int PTR_DIST  = 2;
    localparam int WIN8_LEN  = 8;
    localparam int WIN16_LEN = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_QUIET,
        ST_APPLY,
        ST_FLUSH
    } state_t;

    function automatic logic is_long_window(input logic [1:0] mode);
        return mode == MODE_WIN16;
    endfunction

endpackage

// File: rtl/ldtu_sat_counter.sv
// Saturating up-counter: counts inc pulses and holds at all-ones.
module ldtu_sat_counter #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         rst_b,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge CLK or negedge rst_b) begin
        if (!rst_b) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/ldtu_gain_mode_ctrl.sv
// Run-time GAIN_SEL_MODE controller: defers mode changes past active gain-x1 windows,
// masks the iFIFO output while it flushes. Forced-switch timeout under LDTU_MODE_TIMEOUT_EN.
module ldtu_gain_mode_ctrl
    import ldtu_pkg::*;
#(
    parameter logic [1:0] RESET_MODE  = MODE_WIN8,
    parameter int         FLUSH_SHORT = WIN8_LEN + PTR_DIST,
    parameter int         FLUSH_LONG  = WIN16_LEN + PTR_DIST,
    parameter int         TIMEOUT     = 255,
    parameter int         CNT_W       = 8
) (
    input  logic             CLK,
    input  logic             rst_b,
    input  logic [1:0]       mode_req,
    input  logic             mode_req_valid,
    output logic             mode_req_ready,
    input  logic             win_busy,
    input  logic             err_clr,
    output logic [1:0]       GAIN_SEL_MODE,
    output logic             data_valid,
    output logic             mode_ack,
    output logic             timeout_flag,
    output logic [CNT_W-1:0] switch_cnt
);

    localparam logic [CNT_W-1:0] FLUSH_SHORT_C = CNT_W'(FLUSH_SHORT);
    localparam logic [CNT_W-1:0] FLUSH_LONG_C  = CNT_W'(FLUSH_LONG);
    localparam logic [CNT_W-1:0] RESET_FLUSH   =
        is_long_window(RESET_MODE) ? FLUSH_LONG_C : FLUSH_SHORT_C;

    state_t           state;
    logic [1:0]       pending;
    logic [CNT_W-1:0] flush_cnt;
    logic             post_reset;

`ifdef LDTU_MODE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    logic [CNT_W-1:0] to_cnt;
`else
    wire unused_timeout_cfg = err_clr | (TIMEOUT == 0);
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge CLK or negedge rst_b) begin
        if (!rst_b) begin
            state          <= ST_FLUSH;
            pending        <= RESET_MODE;
            flush_cnt      <= RESET_FLUSH;
            post_reset     <= 1'b1;
            GAIN_SEL_MODE  <= RESET_MODE;
            data_valid     <= 1'b0;
            mode_ack       <= 1'b0;
            mode_req_ready <= 1'b0;
`ifdef LDTU_MODE_TIMEOUT_EN
            to_cnt         <= '0;
            timeout_flag   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking defaults at the top of a clocked block are overridden by
            // any later assignment in the same edge; that gives single-cycle pulses and
            // lets a timeout set beat err_clr without extra priority logic.
            mode_ack <= 1'b0;
`ifdef LDTU_MODE_TIMEOUT_EN
            if (err_clr) begin
                timeout_flag <= 1'b0;
            end
`endif
            unique case (state)
                ST_IDLE: begin
                    if (mode_req_valid) begin
                        if (mode_req == GAIN_SEL_MODE) begin
                            mode_ack <= 1'b1;
                        end else begin
                            pending        <= mode_req;
                            mode_req_ready <= 1'b0;
                            state          <= ST_WAIT_QUIET;
`ifdef LDTU_MODE_TIMEOUT_EN
                            to_cnt         <= '0;
`endif
                        end
                    end
                end

                ST_WAIT_QUIET: begin
                    if (!win_busy) begin
                        state <= ST_APPLY;
`ifdef LDTU_MODE_TIMEOUT_EN
                    end else if (to_cnt == TIMEOUT_C) begin
                        timeout_flag <= 1'b1;
                        state        <= ST_APPLY;
                    end else begin
                        to_cnt <= to_cnt + CNT_W'(1);
`endif
                    end
                end

                ST_APPLY: begin
                    GAIN_SEL_MODE <= pending;
                    data_valid    <= 1'b0;
                    flush_cnt     <= is_long_window(pending) ? FLUSH_LONG_C : FLUSH_SHORT_C;
                    state         <= ST_FLUSH;
                end

                ST_FLUSH: begin
                    // The reset flush completes silently: nobody asked for it.
                    if (flush_cnt == CNT_W'(1)) begin
                        mode_ack       <= ~post_reset;
                        post_reset     <= 1'b0;
                        data_valid     <= 1'b1;
                        mode_req_ready <= 1'b1;
                        state          <= ST_IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - CNT_W'(1);
                    end
                end

                default: state <= ST_FLUSH;
            endcase
        end
    end

    ldtu_sat_counter #(
        .W (CNT_W)
    ) u_switch_cnt (
        .CLK   (CLK),
        .rst_b (rst_b),
        .inc   (state == ST_APPLY),
        .count (switch_cnt)
    );

endmodule

// File: tb/tb_ldtu_gain_mode_ctrl.sv
// Self-checking bench for ldtu_gain_mode_ctrl: directed and random requests checked every
// cycle against a transaction timeline model. Timeout checks follow LDTU_MODE_TIMEOUT_EN.
module tb_ldtu_gain_mode_ctrl;

    localparam int         CNT_W       = 8;
    localparam int         TIMEOUT     = 255;
    localparam int         FLUSH_SHORT = 10;
    localparam int         FLUSH_LONG  = 18;
    localparam logic [1:0] RESET_MODE  = 2'b00;
`ifdef LDTU_MODE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             rst_b = 1'b0;
    logic [1:0]       mode_req = 2'b00;
    logic             mode_req_valid = 1'b0;
    logic             mode_req_ready;
    logic             win_busy = 1'b0;
    logic             err_clr = 1'b0;
    logic [1:0]       GAIN_SEL_MODE;
    logic             data_valid;
    logic             mode_ack;
    logic             timeout_flag;
    logic [CNT_W-1:0] switch_cnt;

    always #5 CLK = ~CLK;

    ldtu_gain_mode_ctrl dut (
        .CLK            (CLK),
        .rst_b          (rst_b),
        .mode_req       (mode_req),
        .mode_req_valid (mode_req_valid),
        .mode_req_ready (mode_req_ready),
        .win_busy       (win_busy),
        .err_clr        (err_clr),
        .GAIN_SEL_MODE  (GAIN_SEL_MODE),
        .data_valid     (data_valid),
        .mode_ack       (mode_ack),
        .timeout_flag   (timeout_flag),
        .switch_cnt     (switch_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: current mode, switch count, sticky timeout flag.
    logic [1:0] m_mode = RESET_MODE;
    int         m_sw   = 0;
    bit         m_flag = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx, input logic [1:0] e_mode, input bit e_dv,
                             input bit e_ack, input bit e_rdy);
        check({ctx, " mode"},  8'(GAIN_SEL_MODE),  8'(e_mode));
        check({ctx, " valid"}, 8'(data_valid),     8'(e_dv));
        check({ctx, " ack"},   8'(mode_ack),       8'(e_ack));
        check({ctx, " ready"}, 8'(mode_req_ready), 8'(e_rdy));
        check({ctx, " tflag"}, 8'(timeout_flag),   8'(m_flag));
        check({ctx, " swcnt"}, switch_cnt,         8'(m_sw));
    endtask

    function automatic int flush_of(input logic [1:0] m);
        return (m == 2'b01) ? FLUSH_LONG : FLUSH_SHORT;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Call just after rst_b rises; the masked reset flush ends with no ack.
    task automatic post_reset_check();
        for (int k = 1; k <= FLUSH_SHORT; k++) begin
            tick();
            check_all($sformatf("rst_k%0d", k), RESET_MODE, k >= FLUSH_SHORT, 1'b0,
                      k >= FLUSH_SHORT);
            mode_req_valid = (k < FLUSH_SHORT) ? 1'($urandom) : 1'b0;
            mode_req       = 2'($urandom);
            win_busy       = 1'($urandom);
        end
        win_busy = 1'b0;
    endtask

    task automatic idle(input int n, input bit clr);
        for (int i = 0; i < n; i++) begin
            err_clr  = clr;
            win_busy = 1'($urandom);
            tick();
            if (clr) m_flag = 1'b0;
            check_all("idle", m_mode, 1'b1, 1'b0, 1'b1);
        end
        err_clr = 1'b0;
    endtask

    // One request from IDLE. busy_len: WAIT_QUIET edges that see win_busy=1.
    // clr_edge: edge index (0 = accept) with err_clr high. abort_at: edge after which
    // rst_b is pulled low. junk: extra valids while the controller is not ready.
    task automatic do_req(input logic [1:0] m, input int busy_len, input int clr_edge,
                          input bit junk, input int abort_at);
        int a;
        int last;
        bit forced;
        bit clr_now;
        mode_req       = m;
        mode_req_valid = 1'b1;
        win_busy       = (busy_len >= 1);
        clr_now        = (clr_edge == 0);
        err_clr        = clr_now;
        if (m == m_mode) begin
            tick();
            mode_req_valid = 1'b0;
            err_clr        = 1'b0;
            if (clr_now) m_flag = 1'b0;
            check_all("same", m_mode, 1'b1, 1'b1, 1'b1);
            tick();
            check_all("same_after", m_mode, 1'b1, 1'b0, 1'b1);
            return;
        end
        forced = TO_EN && (busy_len > TIMEOUT);
        a      = forced ? 2 + TIMEOUT : 2 + busy_len;
        last   = a + flush_of(m);
        for (int k = 0; k <= last; k++) begin
            tick();
            if (forced && k == a - 1) m_flag = 1'b1;
            else if (clr_now)         m_flag = 1'b0;
            if (k == a && m_sw < 255) m_sw++;
            check_all($sformatf("req%0d_k%0d", m, k), (k >= a) ? m : m_mode,
                      !(k >= a && k < last), k == last, k >= last);
            if (k == abort_at) begin
                rst_b  = 1'b0;
                #1;
                m_mode = RESET_MODE;
                m_sw   = 0;
                m_flag = 1'b0;
                check_all("abort", RESET_MODE, 1'b0, 1'b0, 1'b0);
                mode_req_valid = 1'b0;
                win_busy       = 1'b0;
                err_clr        = 1'b0;
                return;
            end
            mode_req_valid = junk && (k + 1 <= last);
            mode_req       = 2'($urandom);
            win_busy       = (k + 1 < a) ? (k + 1 <= busy_len) : 1'($urandom);
            clr_now        = (k + 1 == clr_edge);
            err_clr        = clr_now;
        end
        m_mode         = m;
        mode_req_valid = 1'b0;
        win_busy       = 1'b0;
        err_clr        = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        check_all("in_reset", RESET_MODE, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        rst_b = 1'b1;
        post_reset_check();
        idle(3, 1'b0);

        do_req(2'b00, 0, -1, 1'b0, -1);
        do_req(2'b01, 0, -1, 1'b0, -1);
        do_req(2'b10, 20, -1, 1'b1, -1);
        do_req(2'b10, 0, -1, 1'b0, -1);

        // Stuck window: forced switch with the timeout, plain long wait without.
        do_req(2'b11, 300, -1, 1'b0, -1);
        idle(1, 1'b1);
        idle(2, 1'b0);
        // err_clr on the forcing edge: the set must win.
        do_req(2'b00, 300, 2 + TIMEOUT - 1, 1'b0, -1);
        idle(1, 1'b1);

        do_req(2'b11, 3, -1, 1'b1, 5);
        @(negedge CLK);
        rst_b = 1'b1;
        post_reset_check();
        idle(2, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] m;
            int         busy;
            int         clr;
            m    = 2'($urandom);
            busy = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 30));
            clr  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
            do_req(m, busy, clr, 1'($urandom), -1);
            idle(int'($urandom_range(0, 2)), 1'b0);
        end

        // Drive switch_cnt into saturation.
        for (int i = 0; i < 256; i++) begin
            do_req((m_mode == 2'b00) ? 2'b10 : 2'b00, 0, -1, 1'b0, -1);
        end
        idle(2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
